// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with any depth and programmable flags.
// Offers a registered read mode and a first-word-fall-through read mode.
module fifo_param_sync #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;

  localparam ptr_t          LAST    = ptr_t'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2) begin : g_bad_size
    $fatal(1, "fifo_param_sync: bad width/depth");
  end

  if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL &&
        AF_LEVEL < FIFO_DEPTH)) begin : g_bad_lvl
    $fatal(1, "fifo_param_sync: bad AE/AF levels");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  logic                  wr_do;
  logic                  rd_do;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic ptr_t nxt(input ptr_t p);
    return (p == LAST) ? '0 : p + ptr_t'(1);
  endfunction

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C) && !full;
  assign almostempty = !empty && (count <= AE_C);

  assign wr_do = wr_en && !full;
  assign rd_do = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_do;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_do) wr_ptr <= nxt(wr_ptr);
      if (rd_do) rd_ptr <= nxt(rd_ptr);
      case ({wr_do, rd_do})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     dout_q <= '0;
      else if (rd_do) dout_q <= mem[rd_ptr];
    end

    assign data_out = dout_q;
  end

endmodule
